// File: rtl/roi_mask_writer.sv
// roi_mask_writer: streams the 112x112 ROI capture mask as 784 row-major 16-bit words.
// Optional ROI_MASK_INVERT_EN adds an invert input that complements every mask bit.
module roi_mask_writer #(
    parameter int RESOLUTION = 112,
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [6:0]        row_start,
    input  logic [6:0]        row_end,
    input  logic [6:0]        col_start,
    input  logic [6:0]        col_end,
`ifdef ROI_MASK_INVERT_EN
    input  logic              invert,
`endif
    input  logic              wr_ready,
    output logic              write_enable,
    output logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int         WPR       = RESOLUTION / WORD_W;
    localparam logic [6:0] LAST_ROW  = 7'(RESOLUTION - 1);
    localparam logic [2:0] LAST_WORD = 3'(WPR - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t            r_state, w_next;
    logic [6:0]        r_row, r_rs, r_re, r_cs, r_ce;
    logic [6:0]        w_row, w_rs, w_re, w_cs, w_ce;
    logic [2:0]        r_word, w_word;
    logic              r_inv, w_inv, w_inv_in, r_err;
    logic              w_valid, w_accept, w_xfer, w_last;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [WORD_W-1:0] r_data, w_data;

`ifdef ROI_MASK_INVERT_EN
    assign w_inv_in = invert;
`else
    assign w_inv_in = 1'b0;
`endif

    function automatic logic [WORD_W-1:0] f_mask(input logic [6:0] row, input logic [2:0] word,
                                                 input logic [6:0] rs, input logic [6:0] re,
                                                 input logic [6:0] cs, input logic [6:0] ce,
                                                 input logic inv);
        logic [7:0] col;
        for (int b = 0; b < WORD_W; b++) begin
            col = 8'(word) * 8'(WORD_W) + 8'(b);
            f_mask[b] = inv ^ (row >= rs && row <= re && col >= {1'b0, cs} && col <= {1'b0, ce});
        end
    endfunction

    // addr/data are precomputed for the position the next cycle will present, keeping them registered
    always_comb begin
        w_valid  = row_start <= LAST_ROW && row_end <= LAST_ROW && col_start <= LAST_ROW &&
                   col_end <= LAST_ROW && row_start <= row_end && col_start <= col_end;
        w_accept = start && r_state == IDLE && w_valid;
        w_xfer   = r_state == WRITE && wr_ready;
        w_last   = r_row == LAST_ROW && r_word == LAST_WORD;
        w_rs     = w_accept ? row_start : r_rs;
        w_re     = w_accept ? row_end   : r_re;
        w_cs     = w_accept ? col_start : r_cs;
        w_ce     = w_accept ? col_end   : r_ce;
        w_inv    = w_accept ? w_inv_in  : r_inv;
        w_row    = w_accept ? '0 : (w_xfer && !w_last && r_word == LAST_WORD) ? r_row + 7'd1 : r_row;
        w_word   = w_accept ? '0 : (w_xfer && !w_last) ? (r_word == LAST_WORD ? '0 : r_word + 3'd1) : r_word;
        w_next   = r_state == IDLE  ? (w_accept ? WRITE : IDLE) :
                   r_state == WRITE ? ((w_xfer && w_last) ? DONE : WRITE) : IDLE;
        w_addr   = w_next == WRITE ? ADDR_W'(w_row) * ADDR_W'(WPR) + ADDR_W'(w_word) : '0;
        w_data   = w_next == WRITE ? f_mask(w_row, w_word, w_rs, w_re, w_cs, w_ce, w_inv) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_word  <= '0;
            r_rs    <= '0;
            r_re    <= '0;
            r_cs    <= '0;
            r_ce    <= '0;
            r_inv   <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            r_row   <= w_row;
            r_word  <= w_word;
            r_rs    <= w_rs;
            r_re    <= w_re;
            r_cs    <= w_cs;
            r_ce    <= w_ce;
            r_inv   <= w_inv;
            r_err   <= start && r_state == IDLE && !w_valid;
            r_addr  <= w_addr;
            r_data  <= w_data;
        end
    end

    assign write_enable = r_state == WRITE;
    assign busy         = r_state != IDLE;
    assign done         = r_state == DONE;
    assign error        = r_err;
    assign addr         = r_addr;
    assign data         = r_data;
endmodule

// File: tb/tb_roi_mask_writer.sv
// tb_roi_mask_writer: directed ROI sequences checked every cycle against a pixel-level model.
module tb_roi_mask_writer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  row_start = '0, row_end = '0, col_start = '0, col_end = '0;
    logic        wr_ready = 1'b1;
    logic        write_enable, busy, done, error;
    logic [9:0]  addr;
    logic [15:0] data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nx = 0;
    logic [15:0] cap [0:783];

    int ph = 0;
    int k = 0;
    int mrs = 0, mre = 0, mcs = 0, mce = 0;
    bit m_err = 0;

    roi_mask_writer dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .row_start(row_start), .row_end(row_end), .col_start(col_start), .col_end(col_end),
        .wr_ready(wr_ready), .write_enable(write_enable), .addr(addr), .data(data),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20) $display("FAIL %s got %0h want %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic bit ok_bounds(input int rs, input int re, input int cs, input int ce);
        return rs <= 111 && re <= 111 && cs <= 111 && ce <= 111 && rs <= re && cs <= ce;
    endfunction

    // Expected word k: row k/7, columns 16*(k%7) .. +15, bit set for pixels inside the latched ROI
    function automatic logic [15:0] exp_word(input int kk);
        int r, col;
        logic [15:0] v;
        r = kk / 7;
        for (int b = 0; b < 16; b++) begin
            col = 16 * (kk % 7) + b;
            v[b] = r >= mrs && r <= mre && col >= mcs && col <= mce;
        end
        return v;
    endfunction

    // ph: 0 idle, 1 streaming word k, 2 done pulse
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph <= 0;
            k <= 0;
            m_err <= 0;
        end else begin
            m_err <= ph == 0 && start && !ok_bounds(row_start, row_end, col_start, col_end);
            if (ph == 0 && start && ok_bounds(row_start, row_end, col_start, col_end)) begin
                ph <= 1;
                k <= 0;
                mrs <= row_start;
                mre <= row_end;
                mcs <= col_start;
                mce <= col_end;
            end else if (ph == 1 && wr_ready) begin
                if (k == 783) ph <= 2;
                else k <= k + 1;
            end else if (ph == 2) ph <= 0;
        end
    end

    always @(negedge clk) begin
        chk("write_enable", write_enable, ph == 1);
        chk("busy", busy, ph != 0);
        chk("done", done, ph == 2);
        chk("error", error, m_err);
        if (ph == 1) begin
            chk("addr", addr, k);
            chk("data", data, exp_word(k));
        end
    end

    always @(posedge clk)
        if (reset_n && write_enable && wr_ready && addr < 784) begin
            cap[addr] <= data;
            nx <= nx + 1;
        end

    task automatic run(input int rs, input int re, input int cs, input int ce,
                       input bit bp, input int exp_done, input bit mid_start);
        int n0, nx0, t;
        @(negedge clk);
        row_start = 7'(rs); row_end = 7'(re); col_start = 7'(cs); col_end = 7'(ce);
        start = 1'b1;
        n0 = cyc;
        nx0 = nx;
        t = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            t = cyc - n0;
            wr_ready = bp ? (t % 2 == 1) : 1'b1;
            if (mid_start && t == 100) begin
                start = 1'b1;
                row_start = 7'd0; row_end = 7'd111; col_start = 7'd0; col_end = 7'd111;
            end
            if (t == 1) begin
                chk("first_busy", busy, 1);
                chk("first_we", write_enable, 1);
                chk("first_addr", addr, 0);
            end
        end while (!done && t < 2000);
        chk("done_cycle", t, exp_done);
        chk("transfers", nx - nx0, 784);
    endtask

    task automatic bad(input int rs, input int re, input int cs, input int ce);
        @(negedge clk);
        row_start = 7'(rs); row_end = 7'(re); col_start = 7'(cs); col_end = 7'(ce);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", error, 1);
        chk("err_busy", busy, 0);
        chk("err_we", write_enable, 0);
        @(negedge clk);
        chk("err_clear", error, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we", write_enable, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 111, 0, 111, 0, 785, 0);
        chk("full_w0", cap[0], 16'hFFFF);
        chk("full_w783", cap[783], 16'hFFFF);

        run(5, 5, 20, 20, 0, 785, 0);
        chk("pix_w36", cap[36], 16'h0010);
        chk("pix_w35", cap[35], 16'h0000);
        chk("pix_w37", cap[37], 16'h0000);

        run(0, 0, 14, 17, 0, 785, 1);
        chk("edge_w0", cap[0], 16'hC000);
        chk("edge_w1", cap[1], 16'h0003);
        chk("edge_w2", cap[2], 16'h0000);
        chk("edge_w783", cap[783], 16'h0000);

        run(0, 111, 0, 111, 1, 1568, 0);
        chk("bp_w400", cap[400], 16'hFFFF);

        bad(10, 9, 0, 111);
        bad(0, 111, 0, 112);

        begin
            int t;
            @(negedge clk);
            row_start = 7'd0; row_end = 7'd111; col_start = 7'd0; col_end = 7'd111;
            wr_ready = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            t = 0;
            while (addr != 10'd400 && t < 1000) begin
                @(negedge clk);
                t++;
            end
            chk("reach_400", addr, 400);
            #2 reset_n = 1'b0;
            #1;
            chk("async_we", write_enable, 0);
            chk("async_addr", addr, 0);
            chk("async_data", data, 0);
            chk("async_busy", busy, 0);
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
        end

        run(0, 111, 0, 111, 0, 785, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/roi_mask_writer.md
# roi_mask_writer

Sequencer that programs the 112x112 pixel capture mask from a rectangular region of interest (ROI). Software writes four ROI bounds and pulses `start`; the block walks the whole mask in row-major order and streams 784 16-bit mask words over a single-word write port with ready backpressure. It sits between the APB register bank and the mask storage, and is the writer for the mask's `write_enable`/`addr`/`data` port.

## Interface
- `RESOLUTION`, 112: pixels per row and per column.
- `WORD_W`, 16: mask bits per word.
- `ADDR_W`, 10: word address width. 784 words used, addresses 0..783.
- `clk`  in  1  sole clock, all logic on rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; bounds sampled in the same cycle.
- `row_start`, `row_end`, `col_start`, `col_end`  in  7 each  inclusive ROI bounds.
- `wr_ready`  in  1  sink accepts the current word.
- `write_enable`  out  1  word valid.
- `addr`  out  `ADDR_W`  word address.
- `data`  out  `WORD_W`  mask word.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `error`  out  1  one-cycle pulse when `start` carries invalid bounds.

## Operation
- Word layout: word `r*7 + w` covers row `r`, columns `16w .. 16w+15`. Bit `b` is column `16w+b`, so bit 0 is the lowest column.
- Bit value: 1 iff `row_start<=r<=row_end` and `col_start<=col<=col_end`.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - `start` with valid bounds: latch bounds, set row counter r=0 and word counter w=0, go to WRITE.
  - `start` with invalid bounds: pulse `error` next cycle, stay IDLE, no writes. Bounds are invalid if any bound is >111, `row_start>row_end`, or `col_start>col_end`.
- WRITE: `write_enable`=1 with `addr`/`data` for (r,w).
  - A transfer occurs on a cycle with `write_enable && wr_ready`.
  - On transfer: w increments; at w=6 it wraps to 0 and r increments.
  - Transfer of word 783 (r=111, w=6) goes to DONE.
- DONE: `done`=1 for one cycle, `busy` still 1, then IDLE.
- `start` while `busy`=1 is ignored; latched bounds do not change mid-sequence.
- Reset at any time, including mid-sequence: immediately IDLE, counters cleared, sequence abandoned. No resume.
- Address arithmetic: `addr = r*7 + w`, computed in `ADDR_W` bits. Never exceeds 783.

## Timing
- Reset values: `write_enable`=0, `addr`=0, `data`=0, `busy`=0, `done`=0, `error`=0.
- All outputs are registered.
- `start` in cycle N:
  - Cycle N+1: `busy`=1, `write_enable`=1, `addr`=0.
  - `error` (invalid bounds case) pulses in cycle N+1.
- Hold rule: while `write_enable`=1 and `wr_ready`=0, `addr` and `data` stay stable.
- Throughput: one word per cycle when `wr_ready` is held high.
  - Last transfer in cycle N+784.
  - `done` in cycle N+785.
  - `busy` deasserts in cycle N+786, when a new `start` is accepted.
- `write_enable` is 0 in the DONE cycle.
- `wr_ready` is ignored when `write_enable`=0.

## Configuration
- `ROI_MASK_INVERT_EN` defined:
  - Adds input `invert` (1 bit), sampled with `start` and latched for the sequence.
  - When latched 1, every data bit is complemented, which captures pixels outside the ROI.
  - Bound validity checks are unchanged.
- `ROI_MASK_INVERT_EN` not defined: no `invert` port; behaviour as latched `invert`=0.

## Test plan
- Full frame (0,111,0,111) with `wr_ready`=1 -> 784 writes, addr 0..783 in order, all data 0xFFFF, `done` at N+785.
- Single pixel (row 5..5, col 20..20) -> addr 36 data 0x0010, all other words 0x0000.
- Word-boundary ROI (row 0..0, col 14..17) -> addr 0 data 0xC000, addr 1 data 0x0003, rest 0x0000.
- Backpressure: `wr_ready` alternating 0/1 -> addr/data held on stall cycles, 784 transfers exactly, `done` at N+1568.
- Invalid bounds (`row_start`=10, `row_end`=9), and separately `col_end`=112 -> `error` pulse at N+1, `write_enable` never asserted, `busy` stays 0.
- Reset mid-sequence: `reset_n` low at addr 400 -> all outputs 0 asynchronously. A following `start` restarts at addr 0.
- With `ROI_MASK_INVERT_EN` and `invert`=1, single-pixel case above -> addr 36 data 0xFFEF, others 0xFFFF.
